// File: rtl/melody_sequencer.sv
// melody_sequencer: walks an 8-entry song ROM and drives the buzzer stage.
// Optional tempo scaling input is enabled by defining MELODY_SEQ_TEMPO_EN.
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000,
    parameter int unsigned SONG_LEN    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       loop_i,
`ifdef MELODY_SEQ_TEMPO_EN
    input  logic [1:0] tempo_i,
`endif
    output logic [3:0] note_o,
    output logic       play_tone_o,
    output logic [2:0] step_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [2:0]  LAST_STEP = 3'(SONG_LEN - 1);
    localparam logic [31:0] BEAT_LEN  = 32'(BEAT_CYCLES);
    localparam logic [31:0] GAP_LEN   = 32'(GAP_CYCLES);

    state_t      state;
    logic [2:0]  step;
    logic [31:0] cnt;
    logic [31:0] play_end;
    logic [31:0] gap_end;

    logic [6:0]  entry;
    logic [3:0]  entry_note;
    logic [2:0]  entry_beats;
    logic [31:0] beat_len;
    logic [31:0] note_len;

    // Song ROM: {note[3:0], beats[2:0]}
    function automatic logic [6:0] song_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    song_rom = {4'd1, 3'd1};
            3'd1:    song_rom = {4'd2, 3'd1};
            3'd2:    song_rom = {4'd3, 3'd1};
            3'd3:    song_rom = {4'd0, 3'd1};
            3'd4:    song_rom = {4'd5, 3'd1};
            3'd5:    song_rom = {4'd6, 3'd1};
            3'd6:    song_rom = {4'd7, 3'd1};
            default: song_rom = {4'd8, 3'd2};
        endcase
    endfunction

    // Length of the entry at the current step, in clock cycles
    always_comb begin
        entry       = song_rom(step);
        entry_note  = entry[6:3];
        entry_beats = entry[2:0];
`ifdef MELODY_SEQ_TEMPO_EN
        beat_len    = BEAT_LEN << tempo_i;
`else
        beat_len    = BEAT_LEN;
`endif
        note_len    = 32'(entry_beats) * beat_len;
    end

    assign step_o = step;
    assign busy_o = (state != S_IDLE);

    // Sequencer FSM with registered note/tone/done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            step        <= 3'd0;
            cnt         <= 32'd0;
            play_end    <= 32'd0;
            gap_end     <= 32'd0;
            note_o      <= 4'd0;
            play_tone_o <= 1'b0;
            done_o      <= 1'b0;
        end else if (stop_i && state != S_IDLE) begin
            state       <= S_IDLE;
            step        <= 3'd0;
            cnt         <= 32'd0;
            note_o      <= 4'd0;
            play_tone_o <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    note_o      <= 4'd0;
                    play_tone_o <= 1'b0;
                    if (start_i && !stop_i) begin
                        state <= S_LOAD;
                        step  <= 3'd0;
                    end
                end
                S_LOAD: begin
                    cnt      <= 32'd0;
                    play_end <= note_len - GAP_LEN - 32'd1;
                    gap_end  <= note_len - 32'd1;
                    if (entry_beats == 3'd0) begin
                        state       <= S_DONE;
                        play_tone_o <= 1'b0;
                        done_o      <= 1'b1;
                    end else begin
                        state       <= S_PLAY;
                        note_o      <= entry_note;
                        play_tone_o <= (entry_note != 4'd0);
                    end
                end
                S_PLAY: begin
                    cnt <= cnt + 32'd1;
                    if (cnt == play_end) begin
                        state       <= S_GAP;
                        play_tone_o <= 1'b0;
                    end
                end
                S_GAP: begin
                    cnt <= cnt + 32'd1;
                    if (cnt == gap_end) begin
                        if (step < LAST_STEP) begin
                            step  <= step + 3'd1;
                            state <= S_LOAD;
                        end else if (loop_i) begin
                            step  <= 3'd0;
                            state <= S_LOAD;
                        end else begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    step        <= 3'd0;
                    note_o      <= 4'd0;
                    play_tone_o <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: scoreboard bench for melody_sequencer.
// Expected output timeline comes from a song-level model of the player.
module tb_melody_sequencer;

    localparam int BEAT = 10;
    localparam int GAP  = 2;
    localparam int LEN  = 8;
    localparam int MAXN = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       stop_i;
    logic       loop_i;
    logic [3:0] note_o;
    logic       play_tone_o;
    logic [2:0] step_o;
    logic       busy_o;
    logic       done_o;
`ifdef MELODY_SEQ_TEMPO_EN
    logic [1:0] tempo_i;
`endif

    always #5 clk = ~clk;

    melody_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .SONG_LEN   (LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .loop_i     (loop_i),
`ifdef MELODY_SEQ_TEMPO_EN
        .tempo_i    (tempo_i),
`endif
        .note_o     (note_o),
        .play_tone_o(play_tone_o),
        .step_o     (step_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    typedef struct {
        int note;
        bit note_care;
        bit play;
        int step;
        bit step_care;
        bit busy;
        bit done;
        int cyc;
        int scen;
    } exp_t;

    exp_t sb_q[$];
    exp_t model[MAXN];
    bit   st[MAXN];
    bit   sp[MAXN];
    bit   rs[MAXN];
    bit   lp[MAXN];
    int   n_cyc;
    int   tempo;
    int   scen_id;
    int   checks = 0;
    int   errors = 0;

    int song_note[LEN]  = '{1, 2, 3, 0, 5, 6, 7, 8};
    int song_beats[LEN] = '{1, 1, 1, 1, 1, 1, 1, 2};

    function automatic exp_t mk(int n, bit nc, bit pl, int s,
                                bit sc, bit b, bit d);
        exp_t e;
        e.note = n; e.note_care = nc; e.play = pl;
        e.step = s; e.step_care = sc; e.busy = b; e.done = d;
        e.cyc = 0; e.scen = 0;
        return e;
    endfunction

    // A busy cycle exists only if the previous cycle saw no stop/reset
    function automatic bit emit(int c, exp_t e);
        if (c >= n_cyc) return 1'b0;
        if (sp[c-1] || rs[c-1]) return 1'b0;
        model[c] = e;
        return 1'b1;
    endfunction

    // Plays the song from cycle c0; returns first cycle the player is idle
    function automatic int play_song(int c0);
        int c = c0;
        int k = 0;
        int plen;
        int n;
        while (c < n_cyc) begin
            n = song_note[k];
            if (!emit(c, mk(0, 0, 0, k, 1, 1, 0))) return c;
            c++;
            plen = song_beats[k] * (BEAT << tempo) - GAP;
            for (int i = 0; i < plen; i++) begin
                if (!emit(c, mk(n, 1, n != 0, k, 1, 1, 0))) return c;
                c++;
            end
            for (int i = 0; i < GAP; i++) begin
                if (!emit(c, mk(n, 1, 0, k, 1, 1, 0))) return c;
                c++;
            end
            if (k < LEN - 1) k++;
            else if (lp[c-1]) k = 0;
            else begin
                if (!emit(c, mk(0, 0, 0, 0, 0, 1, 1))) return c;
                return c + 1;
            end
        end
        return c;
    endfunction

    function automatic void build_model();
        int c = 0;
        while (c < n_cyc) begin
            model[c] = mk(0, 1, 0, 0, 1, 0, 0);
            if (st[c] && !sp[c] && !rs[c]) c = play_song(c + 1);
            else c++;
        end
    endfunction

    function automatic void clear_stim(int n);
        n_cyc = n;
        tempo = 0;
        for (int i = 0; i < MAXN; i++) begin
            st[i] = 0; sp[i] = 0; rs[i] = 0; lp[i] = 0;
        end
    endfunction

    function automatic void chk(string nm, exp_t e, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s scen %0d cycle %0d actual %0d required %0d",
                     nm, e.scen, e.cyc, act, req);
        end
    endfunction

    // Monitor: compare every presented cycle against the scoreboard
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("busy", e, int'(busy_o), int'(e.busy));
            chk("done", e, int'(done_o), int'(e.done));
            chk("play_tone", e, int'(play_tone_o), int'(e.play));
            if (e.note_care) chk("note", e, int'(note_o), e.note);
            if (e.step_care) chk("step", e, int'(step_o), e.step);
        end
    end

    task automatic run_scen();
        build_model();
        @(posedge clk);
        #1;
        rst = 1; start_i = 0; stop_i = 0; loop_i = 0;
`ifdef MELODY_SEQ_TEMPO_EN
        tempo_i = 2'(tempo);
`endif
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk);
            #1;
            rst = rs[c]; start_i = st[c]; stop_i = sp[c]; loop_i = lp[c];
            model[c].cyc  = c;
            model[c].scen = scen_id;
            sb_q.push_back(model[c]);
        end
        @(negedge clk);
        scen_id++;
    endtask

    initial begin
        rst = 1; start_i = 0; stop_i = 0; loop_i = 0;
`ifdef MELODY_SEQ_TEMPO_EN
        tempo_i = 2'd0;
`endif
        scen_id = 0;
        repeat (2) @(posedge clk);

        // Basic song, including mute entry and final done pulse
        clear_stim(110); st[0] = 1; run_scen();
        // Looping playback
        clear_stim(120); st[0] = 1;
        for (int i = 0; i < 120; i++) lp[i] = 1;
        run_scen();
        // Abort with stop
        clear_stim(40); st[0] = 1; sp[20] = 1; run_scen();
        // Reset mid-song, ignored start while busy
        clear_stim(60); st[0] = 1; st[5] = 1; rs[50] = 1; run_scen();
        // Start and stop together in idle
        clear_stim(6); st[0] = 1; sp[0] = 1; run_scen();
        // Start held high: restarts after done
        clear_stim(220);
        for (int i = 0; i < 220; i++) st[i] = 1;
        run_scen();

        // Randomized scenarios
        for (int s = 0; s < 8; s++) begin
            bit l;
            clear_stim(300);
`ifdef MELODY_SEQ_TEMPO_EN
            tempo = int'($urandom_range(0, 3));
`endif
            l = 1'($urandom_range(0, 1));
            st[0] = 1;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 39) == 0) l = ~l;
                lp[i] = l;
                if (i > 0) st[i] = ($urandom_range(0, 19) == 0);
                sp[i] = ($urandom_range(0, 199) == 0);
                rs[i] = ($urandom_range(0, 299) == 0);
            end
            run_scen();
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain queue left %0d required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
